// File: rtl/vend_change_dispenser_pkg.sv
// Shared definitions for the vending machine change dispenser:
// coin values in 0.5-yuan units and the one-hot payout state encoding.
package vend_pkg;

   localparam int unsigned DEF_AMT_W    = 4;
   localparam int unsigned COIN05_UNITS = 1;
   localparam int unsigned COIN10_UNITS = 2;

   typedef enum logic [6:0] {
      S_IDLE = 7'b000_0001,
      S_SEL  = 7'b000_0010,
      S_EJ10 = 7'b000_0100,
      S_EJ05 = 7'b000_1000,
      S_GAP  = 7'b001_0000,
      S_DONE = 7'b010_0000,
      S_ERR  = 7'b100_0000
   } state_t;

endpackage

// File: rtl/vend_change_dispenser_ack_timer.sv
// Counts cycles an ejector has been waiting for coin_ack and flags the
// cycle in which the ACK_TIMEOUT-th waiting cycle completes.
module vend_ack_timer #(
   parameter int unsigned ACK_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   // Expiry is raised one count early so the FSM leaves EJ on the edge that
   // ends the ACK_TIMEOUT-th wait cycle, giving exactly ACK_TIMEOUT ejector cycles.
   assign expired = run && (cnt == TO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + TO_W'(1);
      end
   end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout FSM: pays largest coin first through a level/ack hopper
// handshake, falls back to 0.5-yuan coins, and reports done or error.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned AMT_W       = DEF_AMT_W,
   parameter int unsigned ACK_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chg_req,
   input  logic [AMT_W-1:0] chg_amt,
   input  logic             hop10_empty,
   input  logic             hop05_empty,
   input  logic             coin_ack,
   output logic             coin10_ej,
   output logic             coin05_ej,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [AMT_W-1:0] paid_amt
);

   localparam logic [AMT_W-1:0] C10_U = AMT_W'(COIN10_UNITS);
   localparam logic [AMT_W-1:0] C05_U = AMT_W'(COIN05_UNITS);

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] paid_d;
   logic             err_d;
   logic             in_ej;
   logic             expired;

   assign in_ej = (state_q == S_EJ10) || (state_q == S_EJ05);

   vend_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .TO_W        (TO_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_ej),
      .run     (in_ej),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         paid_amt <= '0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         paid_amt <= paid_d;
         err      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      paid_d  = paid_amt;
      err_d   = err;
      unique case (state_q)
         S_IDLE: begin
            if (chg_req) begin
               paid_d = '0;
               err_d  = 1'b0;
               if (chg_amt == '0) begin
                  state_d = S_DONE;
               end else begin
                  rem_d   = chg_amt;
                  state_d = S_SEL;
               end
            end
         end
         S_SEL: begin
            if (rem_q == '0)                           state_d = S_DONE;
            else if (rem_q >= C10_U && !hop10_empty)   state_d = S_EJ10;
            else if (!hop05_empty)                     state_d = S_EJ05;
            else                                       state_d = S_ERR;
         end
         S_EJ10: begin
            if (coin_ack) begin
               rem_d   = rem_q - C10_U;
               paid_d  = paid_amt + C10_U;
               state_d = S_GAP;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_EJ05: begin
            if (coin_ack) begin
               rem_d   = rem_q - C05_U;
               paid_d  = paid_amt + C05_U;
               state_d = S_GAP;
            end else if (expired) begin
               state_d = S_ERR;
            end
         end
         S_GAP:  state_d = S_SEL;
         S_DONE: state_d = S_IDLE;
         S_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are a registered decode of the current state, so they trail
   // the state register by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coin10_ej <= 1'b0;
         coin05_ej <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         coin10_ej <= (state_q == S_EJ10);
         coin05_ej <= (state_q == S_EJ05);
         busy      <= state_q inside {S_SEL, S_EJ10, S_EJ05, S_GAP};
         done      <= (state_q == S_DONE);
      end
   end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Money-out side of the vending machine: the coin-in FSM accepts coins and flags that change is owed; this block pays the change.
- Accepts a change request in half-yuan units and drives the coin hopper ejectors with a level/ack handshake.
- Pays largest-coin-first (1.0 yuan, then 0.5 yuan), falls back to 0.5 yuan coins when the 1.0 hopper is empty, and reports done or error.

Parameters:
AMT_W  4  width of the change amount in 0.5-yuan units (max 15 = 7.5 yuan)
ACK_TIMEOUT  15  cycles an eject may wait for coin_ack before error
TO_W  4  timeout counter width; must satisfy 2**TO_W > ACK_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
chg_req  in  1  1-cycle change request pulse
chg_amt  in  AMT_W  change owed in 0.5-yuan units; valid with chg_req
hop10_empty  in  1  1.0-yuan hopper empty
hop05_empty  in  1  0.5-yuan hopper empty
coin_ack  in  1  hopper confirms one coin ejected
coin10_ej  out  1  eject one 1.0-yuan coin; held until ack
coin05_ej  out  1  eject one 0.5-yuan coin; held until ack
busy  out  1  request in progress
done  out  1  1-cycle pulse: full amount paid
err  out  1  sticky: payout aborted
paid_amt  out  AMT_W  running total paid in 0.5-yuan units

Behaviour:
- Async reset (rst=0): state IDLE; all outputs 0; remaining, paid_amt and timer cleared. Reset mid-eject drops the ejector at once; the coin is not counted.
- All outputs are registered (Moore decode of state plus registers).
- States: IDLE, SEL, EJ10, EJ05, GAP, DONE, ERR.
- IDLE:
  - chg_req with chg_amt!=0: latch remaining=chg_amt; paid_amt=0; clear err; go SEL.
  - chg_req with chg_amt==0: go DONE; no coins.
- SEL (busy=1), first match wins:
  - remaining==0 -> DONE
  - remaining>=2 and !hop10_empty -> EJ10
  - remaining>=1 and !hop05_empty -> EJ05
  - otherwise -> ERR
- EJ10 / EJ05:
  - coin10_ej / coin05_ej = 1; timer counts from 0.
  - On coin_ack=1: remaining -= 2 (or 1); paid_amt += 2 (or 1); go GAP.
  - If the timer reaches ACK_TIMEOUT without ack -> ERR; the coin is not counted.
- GAP: one cycle with both ejectors low (hopper spacing), then SEL.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE.
- ERR: err=1, busy=0, ejectors low; -> IDLE next cycle. err stays high until reset or the next accepted chg_req. paid_amt holds the partial total.
- Latency: chg_req at edge N gives busy at N+1 and the first ejector at N+2. Acked coin at edge M gives the ejector low at M+1 and the next ejector at M+3.
- Boundary rules:
  - chg_req while busy is ignored.
  - coin_ack outside EJ states is ignored.
  - Hopper-empty flags are sampled only in SEL; a flag change during EJ does not abort the current coin.
  - coin10_ej and coin05_ej are never high together.
  - remaining never underflows: EJ10 is entered only when remaining>=2.

Decomposition:
- Package vend_pkg:
  - coin value constants COIN05_UNITS=1, COIN10_UNITS=2
  - state localparams, one-hot, 7 bits, matching the coin-in FSM style
  - default AMT_W
- Sub-module vend_ack_timer:
  - Inputs: clear, run. Output: expired at ACK_TIMEOUT.
  - The only natural split; the rest stays in one module.

Test Plan:
- chg_amt=3, both hoppers full, ack 1 cycle after each eject -> one coin10_ej, one coin05_ej; done pulse; paid_amt=3; err=0.
- chg_amt=5, hop10_empty=1 -> five coin05_ej handshakes, each separated by at least one low cycle; done; paid_amt=5.
- chg_amt=4, hop10_empty rises after the first 1.0 coin is acked -> sequence 10, 05, 05; paid_amt=4; done.
- chg_amt=1, hop05_empty=1 -> no ejector asserted; err=1; paid_amt=0.
- chg_amt=2, coin_ack never asserted -> coin10_ej high for 15 cycles, then err=1, ejector low, paid_amt=0. A new chg_req clears err.
- chg_amt=0 -> done after 2 cycles with no ejects.
- chg_req during busy -> ignored.
- rst low mid-EJ10 -> all outputs 0 immediately.
